// File: rtl/fn_suma_resta_serie.sv
// -----------------------------------------------------------------------------
// fn_suma_resta_serie
//
// Digit-serial add/subtract unit. Computes a+b or a-b CHUNK bits per clock
// through a single CHUNK-bit adder, so a WIDTH-bit operation takes
// N = WIDTH/CHUNK cycles. Status flags (carry, overflow, zero, negative) are
// registered together with the last result chunk. Operands enter and results
// leave through valid/ready handshakes; only one operation is in flight.
//
// Ports:
//   clk        system clock, rising edge
//   nreset     asynchronous active-low reset
//   in_valid   operands presented            in_ready   unit accepts operands (IDLE)
//   a, b       WIDTH-bit operands            resta      0 = a+b, 1 = a-b
//   out_valid  result and flags valid (DONE) out_ready  consumer takes result
//   Y          result modulo 2^WIDTH
//   carry      carry out of MSB (subtraction: 1 = no borrow)
//   overflow   two's-complement signed overflow
//   zero       Y == 0
//   negative   Y[WIDTH-1]
// -----------------------------------------------------------------------------
module fn_suma_resta_serie #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             resta,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("fn_suma_resta_serie: CHUNK must divide WIDTH exactly");
        end
    endgenerate

    logic [1:0]                 state;
    logic [CW-1:0]              cnt;
    logic                       cy;
    logic [WIDTH-1:0]           a_sh;
    logic [WIDTH-1:0]           b_sh;
    logic                       zacc;
    logic [N-1:0][CHUNK-1:0]    y_q;
    logic [CHUNK:0]             sum;
    logic                       last;
    logic                       sum_zero;

    // Operands are shifted right one chunk per cycle, so the chunk under
    // work is always in the low CHUNK bits. On the final chunk those low
    // bits hold the operand MSB chunk, which is what the overflow flag needs.
    always_comb begin
        sum      = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, cy};
        last     = (cnt == LAST);
        sum_zero = (sum[CHUNK-1:0] == '0);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Y         = y_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            cnt      <= '0;
            cy       <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            zacc     <= 1'b0;
            y_q      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction as a + ~b + 1: the +1 rides in on the carry.
                        a_sh  <= a;
                        b_sh  <= resta ? ~b : b;
                        cy    <= resta;
                        cnt   <= '0;
                        zacc  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    y_q[cnt] <= sum[CHUNK-1:0];
                    cy       <= sum[CHUNK];
                    cnt      <= cnt + CW'(1);
                    a_sh     <= a_sh >> CHUNK;
                    b_sh     <= b_sh >> CHUNK;
                    // Running "all chunks so far were zero" avoids a wide compare.
                    zacc     <= zacc & sum_zero;
                    if (last) begin
                        carry    <= sum[CHUNK];
                        overflow <= (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                                    (sum[CHUNK-1] != a_sh[CHUNK-1]);
                        zero     <= zacc & sum_zero;
                        negative <= sum[CHUNK-1];
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fn_suma_resta_serie.sv
// -----------------------------------------------------------------------------
// tb_fn_suma_resta_serie
//
// Directed bench for fn_suma_resta_serie. Three instances share one stimulus:
//   u_a : WIDTH=32, CHUNK=8   (latency 4)
//   u_b : WIDTH=32, CHUNK=32  (latency 1)
//   u_c : WIDTH=16, CHUNK=4   (latency 4, operands are the low 16 bits)
// Flags are compared as {carry, overflow, zero, negative}.
// -----------------------------------------------------------------------------
module tb_fn_suma_resta_serie;

    logic        clk       = 1'b0;
    logic        nreset    = 1'b1;
    logic        in_valid  = 1'b0;
    logic        resta     = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;

    logic        ir_a, ov_a, c_a, v_a, z_a, n_a;
    logic        ir_b, ov_b, c_b, v_b, z_b, n_b;
    logic        ir_c, ov_c, c_c, v_c, z_c, n_c;
    logic [31:0] y_a, y_b;
    logic [15:0] y_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fn_suma_resta_serie #(.WIDTH(32), .CHUNK(8)) u_a (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(ir_a),
        .a(a), .b(b), .resta(resta), .out_valid(ov_a), .out_ready(out_ready),
        .Y(y_a), .carry(c_a), .overflow(v_a), .zero(z_a), .negative(n_a)
    );

    fn_suma_resta_serie #(.WIDTH(32), .CHUNK(32)) u_b (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(ir_b),
        .a(a), .b(b), .resta(resta), .out_valid(ov_b), .out_ready(out_ready),
        .Y(y_b), .carry(c_b), .overflow(v_b), .zero(z_b), .negative(n_b)
    );

    fn_suma_resta_serie #(.WIDTH(16), .CHUNK(4)) u_c (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(ir_c),
        .a(a[15:0]), .b(b[15:0]), .resta(resta), .out_valid(ov_c), .out_ready(out_ready),
        .Y(y_c), .carry(c_c), .overflow(v_c), .zero(z_c), .negative(n_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until all three instances present a result.
    task automatic wait_all_valid(input string nm);
        for (int k = 0; k < 12; k++) begin
            if (ov_a && ov_b && ov_c) break;
            @(posedge clk); #1;
        end
        check({nm, ".valid"}, {29'd0, ov_a, ov_b, ov_c}, 32'd7);
    endtask

    task automatic pop(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, ".pop_idle"}, {26'd0, ov_a, ov_b, ov_c, ir_a, ir_b, ir_c}, 32'h7);
    endtask

    // One full transaction: accept, scramble inputs mid-CALC, measure latency,
    // hold under backpressure, check results and flags, then pop.
    task automatic op(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                      input logic ir, input logic [31:0] ey, input logic [3:0] ef,
                      input logic [15:0] ey16, input logic [3:0] ef16);
        int la, lb, lc;
        la = 0; lb = 0; lc = 0;
        @(negedge clk);
        a = ia; b = ib; resta = ir; in_valid = 1'b1; out_ready = 1'b0;
        check({nm, ".ready_idle"}, {29'd0, ir_a, ir_b, ir_c}, 32'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ia; b = ia ^ ib ^ 32'h5A5A5A5A; resta = ~ir;
        check({nm, ".busy"}, {28'd0, ir_a, ir_b, ir_c, ov_a | ov_b | ov_c}, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (la == 0 && ov_a) la = k;
            if (lb == 0 && ov_b) lb = k;
            if (lc == 0 && ov_c) lc = k;
            if (la != 0 && lb != 0 && lc != 0) break;
        end
        check({nm, ".lat_w32c8"},  la, 32'd4);
        check({nm, ".lat_w32c32"}, lb, 32'd1);
        check({nm, ".lat_w16c4"},  lc, 32'd4);
        repeat (5) begin
            @(posedge clk); #1;
            a = 32'hCAFEF00D; b = 32'h0BADBEEF;
        end
        check({nm, ".held"}, {26'd0, ov_a, ov_b, ov_c, ir_a, ir_b, ir_c}, 32'h38);
        check({nm, ".y_w32c8"},  y_a, ey);
        check({nm, ".f_w32c8"},  {28'd0, c_a, v_a, z_a, n_a}, {28'd0, ef});
        check({nm, ".y_w32c32"}, y_b, ey);
        check({nm, ".f_w32c32"}, {28'd0, c_b, v_b, z_b, n_b}, {28'd0, ef});
        check({nm, ".y_w16c4"},  {16'd0, y_c}, {16'd0, ey16});
        check({nm, ".f_w16c4"},  {28'd0, c_c, v_c, z_c, n_c}, {28'd0, ef16});
        pop(nm);
        check({nm, ".y_kept"}, y_a, ey);
    endtask

    initial begin
        // Reset state
        #2 nreset = 1'b0;
        #1;
        check("rst.y_a", y_a, 32'd0);
        check("rst.y_b", y_b, 32'd0);
        check("rst.y_c", {16'd0, y_c}, 32'd0);
        check("rst.ctrl", {26'd0, ov_a, ov_b, ov_c, ir_a, ir_b, ir_c}, 32'h7);
        check("rst.flags", {20'd0, c_a, v_a, z_a, n_a, c_b, v_b, z_b, n_b, c_c, v_c, z_c, n_c}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;

        //  name       a             b             resta  Y32           {c,v,z,n}  Y16       {c,v,z,n}
        op("add",     32'd15,       32'd10,       1'b0,  32'd25,       4'b0000,   16'd25,   4'b0000);
        op("sub",     32'd15,       32'd10,       1'b1,  32'd5,        4'b1000,   16'd5,    4'b1000);
        op("sub_neg", 32'd10,       32'd15,       1'b1,  32'hFFFFFFFB, 4'b0001,   16'hFFFB, 4'b0001);
        op("ovf",     32'h7FFFFFFF, 32'd1,        1'b0,  32'h80000000, 4'b0101,   16'h0000, 4'b1010);
        op("wrap",    32'hFFFFFFFF, 32'd1,        1'b0,  32'h00000000, 4'b1010,   16'h0000, 4'b1010);
        op("ovf16",   32'h00007FFF, 32'd1,        1'b0,  32'h00008000, 4'b0000,   16'h8000, 4'b0101);
        op("sub_eq",  32'h00001234, 32'h00001234, 1'b1,  32'h00000000, 4'b1010,   16'h0000, 4'b1010);
        op("sub_ovf", 32'h80000000, 32'd1,        1'b1,  32'h7FFFFFFF, 4'b1100,   16'hFFFF, 4'b0001);

        // Back-to-back: in_valid held high through DONE must not restart.
        @(negedge clk);
        a = 32'd3; b = 32'd4; resta = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'd100; b = 32'd200;
        wait_all_valid("b2b1");
        repeat (3) begin @(posedge clk); #1; end
        check("b2b1.held", {29'd0, ov_a, ov_b, ov_c}, 32'd7);
        check("b2b1.y_a", y_a, 32'd7);
        check("b2b1.y_b", y_b, 32'd7);
        check("b2b1.y_c", {16'd0, y_c}, 32'd7);
        pop("b2b1");
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b2.accepted", {29'd0, ir_a, ir_b, ir_c}, 32'd0);
        wait_all_valid("b2b2");
        check("b2b2.y_a", y_a, 32'd300);
        check("b2b2.y_b", y_b, 32'd300);
        check("b2b2.y_c", {16'd0, y_c}, 32'd300);
        pop("b2b2");

        // Reset two cycles into CALC: abort, clear outputs, no result pulse.
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; resta = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("abort.pre_y_b", y_b, 32'h23456789);
        nreset = 1'b0;
        #1;
        check("abort.y_a", y_a, 32'd0);
        check("abort.y_b", y_b, 32'd0);
        check("abort.y_c", {16'd0, y_c}, 32'd0);
        check("abort.ctrl", {26'd0, ov_a, ov_b, ov_c, ir_a, ir_b, ir_c}, 32'h7);
        check("abort.flags", {20'd0, c_a, v_a, z_a, n_a, c_b, v_b, z_b, n_b, c_c, v_c, z_c, n_c}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort.no_pulse", {26'd0, ov_a, ov_b, ov_c, ir_a, ir_b, ir_c}, 32'h7);
        op("after_rst", 32'd3, 32'd4, 1'b0, 32'd7, 4'b0000, 16'd7, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
